// File: rtl/mem_resp_pkg.sv
// Shared widths and FSM state encoding for the memory responder.
package mem_resp_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Single-port DEPTH x 16 storage: synchronous write, registered read output.
// Contents survive reset; only the read register is cleared.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int IDX_W = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic              rd_clr,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // rd_clr loads zero for a read that targets no real location
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Four-phase memory responder with programmable wait states.
// Optional MEM_RESP_ADDR_CHECK_EN adds range checking and the err output.
//
//   state | meaning
//   IDLE  | waiting for mem_en; request fields latched on acceptance
//   WAIT  | counting down wait states; access happens when count is zero
//   ACK   | mfc high; held until the initiator drops mem_en
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              mfc
`ifdef MEM_RESP_ADDR_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int IDX_W = idx_width(DEPTH);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_rw;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              access;

`ifdef MEM_RESP_ADDR_CHECK_EN
    assign in_range = int'(lat_addr) < DEPTH;
    assign idx      = IDX_W'(lat_addr);
    assign err      = (state == ACK) && !in_range;
`else
    assign in_range = 1'b1;
    assign idx      = IDX_W'(int'(lat_addr) % DEPTH);
`endif

    // rst gating keeps a reset on the completing edge from committing a write
    assign access = !rst && (state == WAIT) && (cnt == '0) && mem_en;
    assign mfc    = (state == ACK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_en) begin
                        state <= WAIT;
                        cnt   <= CNT_W'(WAIT_CYCLES);
                    end
                end
                WAIT: begin
                    if (!mem_en) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state <= ACK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    if (!mem_en) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && mem_en) begin
            lat_rw   <= rw;
            lat_addr <= addr;
            lat_data <= data_in;
        end
    end

    mem_resp_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .we     (access && lat_rw && in_range),
        .re     (access && !lat_rw && in_range),
        .rd_clr (access && !lat_rw && !in_range),
        .idx    (idx),
        .wdata  (lat_data),
        .rdata  (data_out)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: two instances (2 and 0 wait states).
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rw;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        mem_en_a, mem_en_b;
    logic [15:0] dout_a, dout_b;
    logic        mfc_a, mfc_b;
`ifdef MEM_RESP_ADDR_CHECK_EN
    logic        err_a, err_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .mem_en   (mem_en_a),
        .rw       (rw),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (dout_a),
        .mfc      (mfc_a)
`ifdef MEM_RESP_ADDR_CHECK_EN
        ,
        .err      (err_a)
`endif
    );

    mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .mem_en   (mem_en_b),
        .rw       (rw),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (dout_b),
        .mfc      (mfc_b)
`ifdef MEM_RESP_ADDR_CHECK_EN
        ,
        .err      (err_b)
`endif
    );

    // Full handshake; request fields are scrambled right after sampling.
    task automatic do_access(input bit sel, input logic wr, input logic [15:0] a,
                             input logic [15:0] d, input int hold,
                             output int lat, output logic [15:0] rdata,
                             output logic err_seen, output logic hold_ok,
                             output logic mfc_after);
        lat = -1;
        hold_ok = 1'b1;
        err_seen = 1'b0;
        rdata = 16'hxxxx;
        @(negedge clk);
        rw = wr; addr = a; data_in = d;
        if (sel) mem_en_b = 1'b1; else mem_en_a = 1'b1;
        @(posedge clk); #1;
        rw = ~wr; addr = ~a; data_in = ~d;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if ((sel ? mfc_b : mfc_a) === 1'b1) begin
                lat = i;
                break;
            end
        end
        rdata = sel ? dout_b : dout_a;
`ifdef MEM_RESP_ADDR_CHECK_EN
        err_seen = sel ? err_b : err_a;
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if ((sel ? mfc_b : mfc_a) !== 1'b1) hold_ok = 1'b0;
        end
        @(negedge clk);
        mem_en_a = 1'b0; mem_en_b = 1'b0;
        @(posedge clk); #1;
        mfc_after = sel ? mfc_b : mfc_a;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_en_a = 1'b0; mem_en_b = 1'b0;
        rw = 1'b0; addr = 16'h0; data_in = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mfc_a !== 1'b0 || mfc_b !== 1'b0) begin
            errors++; $display("FAIL reset_mfc: got a=%b b=%b, want 0", mfc_a, mfc_b);
        end
        checks++;
        if (dout_a !== 16'h0000 || dout_b !== 16'h0000) begin
            errors++; $display("FAIL reset_dout: got a=%h b=%h, want 0000", dout_a, dout_b);
        end
`ifdef MEM_RESP_ADDR_CHECK_EN
        checks++;
        if (err_a !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b, want 0", err_a);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        int lat; logic [15:0] rd; logic e, h, m;
        do_access(0, 1'b1, 16'h0010, 16'hBEEF, 0, lat, rd, e, h, m);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d, want 3", lat); end
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL wr_dout_kept: got %h, want 0000", rd); end
        checks++;
        if (m !== 1'b0) begin errors++; $display("FAIL wr_mfc_drop: got %b, want 0", m); end
        do_access(0, 1'b1, 16'h0020, 16'h5555, 0, lat, rd, e, h, m);
        do_access(0, 1'b0, 16'h0010, 16'h0000, 0, lat, rd, e, h, m);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d, want 3", lat); end
        checks++;
        if (rd !== 16'hBEEF) begin errors++; $display("FAIL rd_data: got %h, want BEEF", rd); end
        do_access(0, 1'b1, 16'h0011, 16'h1357, 0, lat, rd, e, h, m);
        checks++;
        if (rd !== 16'hBEEF) begin errors++; $display("FAIL wr_no_dout: got %h, want BEEF", rd); end
    endtask

    task automatic test_hold();
        int lat; logic [15:0] rd; logic e, h, m;
        do_access(0, 1'b1, 16'h0030, 16'hA5A5, 5, lat, rd, e, h, m);
        checks++;
        if (h !== 1'b1) begin errors++; $display("FAIL hold_mfc: got %b, want 1", h); end
        checks++;
        if (m !== 1'b0) begin errors++; $display("FAIL hold_drop: got %b, want 0", m); end
        do_access(0, 1'b0, 16'h0030, 16'h0000, 0, lat, rd, e, h, m);
        checks++;
        if (rd !== 16'hA5A5) begin errors++; $display("FAIL hold_data: got %h, want A5A5", rd); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] rd; logic e, h, m;
        do_access(0, 1'b1, 16'h0050, 16'h0BAD, 0, lat, rd, e, h, m);
        do_access(0, 1'b0, 16'h0050, 16'h0000, 0, lat, rd, e, h, m);
        checks++;
        if (lat !== 3 || rd !== 16'h0BAD) begin
            errors++; $display("FAIL b2b_read: got lat=%0d data=%h, want 3/0BAD", lat, rd);
        end
    endtask

    task automatic test_abort();
        int lat; int seen; logic [15:0] rd; logic e, h, m;
        seen = 0;
        @(negedge clk);
        rw = 1'b1; addr = 16'h0020; data_in = 16'h1234; mem_en_a = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        mem_en_a = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (mfc_a !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL abort_mfc: got %0d mfc cycles, want 0", seen); end
        do_access(0, 1'b0, 16'h0020, 16'h0000, 0, lat, rd, e, h, m);
        checks++;
        if (rd !== 16'h5555) begin errors++; $display("FAIL abort_data: got %h, want 5555", rd); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [15:0] rd; logic e, h, m;
        do_access(0, 1'b1, 16'h0040, 16'h7777, 0, lat, rd, e, h, m);
        do_access(0, 1'b0, 16'h0010, 16'h0000, 0, lat, rd, e, h, m);
        @(negedge clk);
        rw = 1'b1; addr = 16'h0040; data_in = 16'hAAAA; mem_en_a = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mfc_a !== 1'b0 || dout_a !== 16'h0000) begin
            errors++; $display("FAIL rst_mid: got mfc=%b dout=%h, want 0/0000", mfc_a, dout_a);
        end
        @(negedge clk);
        mem_en_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_access(0, 1'b0, 16'h0040, 16'h0000, 0, lat, rd, e, h, m);
        checks++;
        if (rd !== 16'h7777) begin errors++; $display("FAIL rst_no_write: got %h, want 7777", rd); end
        do_access(0, 1'b0, 16'h0010, 16'h0000, 0, lat, rd, e, h, m);
        checks++;
        if (rd !== 16'hBEEF) begin errors++; $display("FAIL rst_keep: got %h, want BEEF", rd); end
    endtask

    task automatic test_wait0();
        int lat; logic [15:0] rd; logic e, h, m;
        do_access(1, 1'b1, 16'h0003, 16'h3C3C, 0, lat, rd, e, h, m);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL w0_wr_latency: got %0d, want 1", lat); end
        do_access(1, 1'b0, 16'h0003, 16'h0000, 0, lat, rd, e, h, m);
        checks++;
        if (lat !== 1 || rd !== 16'h3C3C) begin
            errors++; $display("FAIL w0_read: got lat=%0d data=%h, want 1/3C3C", lat, rd);
        end
        checks++;
        if (m !== 1'b0) begin errors++; $display("FAIL w0_drop: got %b, want 0", m); end
    endtask

    task automatic test_range();
        int lat; logic [15:0] rd; logic e, h, m;
        do_access(0, 1'b1, 16'h0005, 16'h1111, 0, lat, rd, e, h, m);
        do_access(0, 1'b1, 16'h0105, 16'h0F0F, 0, lat, rd, e, h, m);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL oor_wr_latency: got %0d, want 3", lat); end
`ifdef MEM_RESP_ADDR_CHECK_EN
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b, want 1", e); end
        do_access(0, 1'b0, 16'h0105, 16'h0000, 0, lat, rd, e, h, m);
        checks++;
        if (rd !== 16'h0000 || e !== 1'b1) begin
            errors++; $display("FAIL oor_read: got data=%h err=%b, want 0000/1", rd, e);
        end
        checks++;
        if (err_a !== 1'b0) begin errors++; $display("FAIL oor_err_idle: got %b, want 0", err_a); end
        do_access(0, 1'b0, 16'h0005, 16'h0000, 0, lat, rd, e, h, m);
        checks++;
        if (rd !== 16'h1111 || e !== 1'b0) begin
            errors++; $display("FAIL oor_no_alias: got data=%h err=%b, want 1111/0", rd, e);
        end
`else
        do_access(0, 1'b0, 16'h0005, 16'h0000, 0, lat, rd, e, h, m);
        checks++;
        if (rd !== 16'h0F0F) begin errors++; $display("FAIL wrap_alias: got %h, want 0F0F", rd); end
        do_access(0, 1'b0, 16'h0105, 16'h0000, 0, lat, rd, e, h, m);
        checks++;
        if (rd !== 16'h0F0F) begin errors++; $display("FAIL wrap_read: got %h, want 0F0F", rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_hold();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_wait0();
        test_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256: number of 16-bit words stored.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2: wait states inserted before the access completes; legal range 0..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port mem_en, input, 1 bit: request from the initiator; held high until mfc is seen.
REQ-006 The block SHALL have port rw, input, 1 bit: 1 = write, 0 = read; sampled with mem_en.
REQ-007 The block SHALL have port addr, input, 16 bits: word address from the MAR.
REQ-008 The block SHALL have port data_in, input, 16 bits: write data from the MDR write register.
REQ-009 The block SHALL have port data_out, output, 16 bits: read data for the MDR read register.
REQ-010 The block SHALL have port mfc, output, 1 bit: memory function complete.
REQ-011 The block SHALL have port err, output, 1 bit: address error flag; present only with MEM_RESP_ADDR_CHECK_EN.

Function
REQ-012 The FSM SHALL have three states: IDLE, WAIT, ACK.
REQ-013 IDLE SHALL do the following when mem_en=1 at an edge: latch addr, rw and data_in, load the wait counter with WAIT_CYCLES, and go to WAIT.
REQ-014 WAIT SHALL decrement the counter each cycle; at counter=0 it performs the access and goes to ACK.
REQ-015 With WAIT_CYCLES=0, the access SHALL complete one cycle after the request is sampled.
REQ-016 mfc SHALL be 1 exactly while in ACK; it rises WAIT_CYCLES+1 edges after the edge that sampled mem_en=1.
REQ-017 A write SHALL store the latched data_in at the latched addr on the edge entering ACK; data_out is unchanged by a write.
REQ-018 A read SHALL load data_out on the edge entering ACK; data_out holds that value until the next completed read.
REQ-019 ACK SHALL remain while mem_en=1 (four-phase handshake); mem_en=0 returns to IDLE with mfc low on the next cycle.
REQ-020 A new request SHALL NOT be accepted in the same cycle as the ACK to IDLE transition; the minimum gap is one IDLE cycle.
REQ-021 mem_en falling during WAIT SHALL abort: return to IDLE, with no write, no data_out update, and no mfc.
REQ-022 Changes on addr, rw or data_in after sampling SHALL be ignored until the next request.
REQ-023 Without MEM_RESP_ADDR_CHECK_EN, the address SHALL be reduced modulo DEPTH (wrap-around).

Reset
REQ-024 rst=1 at an edge SHALL force state IDLE, counter 0, mfc 0, data_out 16'h0000, and err 0.
REQ-025 Reset mid-operation SHALL discard a pending access; a write in WAIT is not performed.
REQ-026 Storage contents SHALL NOT be cleared by reset.
REQ-027 Reset SHALL have priority over every other event.

Configuration
REQ-028 Macro MEM_RESP_ADDR_CHECK_EN SHALL enable range checking and the err port.
REQ-029 With the macro enabled, an access with addr >= DEPTH SHALL complete the handshake normally and set err=1 while in ACK. A write stores nothing; a read returns 16'h0000.
REQ-030 With the macro enabled, err SHALL be 0 in all other states.
REQ-031 Without the macro, the err port SHALL be absent and REQ-023 applies.

Structure
REQ-032 Package mem_resp_pkg SHALL hold DATA_W=16, ADDR_W=16, and the state encoding (IDLE=2'd0, WAIT=2'd1, ACK=2'd2).
REQ-033 Storage SHALL be a sub-module mem_resp_array: synchronous write and registered read, one port, DEPTH x 16.
REQ-034 The FSM, wait counter and request latches SHALL live in mem_responder.

Verification
REQ-035 Write then read, WAIT_CYCLES=2: write addr=0x0010, data=0xBEEF; mfc rises 3 edges after request; later read of 0x0010 gives data_out=0xBEEF with mfc.
REQ-036 Handshake hold: keep mem_en high 5 cycles in ACK -> mfc stays 1, no second access; drop mem_en -> mfc=0 next cycle.
REQ-037 Abort: write 0x1234 to 0x0020, drop mem_en in WAIT -> no mfc; read of 0x0020 returns its prior value.
REQ-038 Reset mid-write: assert rst in WAIT -> mfc=0, data_out=0x0000; the location is unmodified; stored data from earlier writes survives.
REQ-039 WAIT_CYCLES=0: read request -> mfc at the next edge.
REQ-040 Out of range, DEPTH=256: access to addr=0x0105. With the macro -> err=1 and read data 0x0000. Without the macro -> access aliases to 0x0005.
